// File: rtl/axis_udp_gen_pkg.sv
// Shared definitions for the UDP generator TX controller: FSM encodings,
// byte-count sizing and the last-beat keep-mask helper.
package axis_udp_gen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SEND  = 2'd1;
    localparam state_t ST_GAP   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Widest byte-count field, reached at the 512-bit data width.
    localparam int MAX_BCW = 7;

    function automatic int bcount_width(input int data_w);
        return $clog2(data_w / 8) + 1;
    endfunction

    // One bit of the keep mask: zero or an oversized count means a full beat.
    function automatic logic keep_bit(input int keep_w, input int idx,
                                      input logic [MAX_BCW-1:0] nbytes);
        int n;
        n = int'(nbytes);
        if (n == 0 || n >= keep_w) return 1'b1;
        return idx < n;
    endfunction

endpackage

// File: rtl/axis_udp_gen_skid.sv
// Output register plus one-entry skid buffer. The upstream side may push only
// while skid_valid is low, so backpressure never reaches it combinationally.
module axis_udp_gen_skid #(
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    output logic [PW-1:0] out_data,
    input  logic          out_ready,
    output logic          skid_valid
);

    logic [PW-1:0] skid_data;
    logic          out_free;

    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_free) begin
            if (skid_valid) begin
                // Oldest beat first; a same-cycle push refills the skid.
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= in_valid;
                if (in_valid) skid_data <= in_data;
            end else if (in_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/axis_udp_gen_tx_ctrl.sv
// Frame/gap sequencer between a beat generator and an AXI-Stream master port.
// Counts frames, inserts inter-frame idle gaps and drains cleanly on stop.
module axis_udp_gen_tx_ctrl
    import axis_udp_gen_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int IFG_WIDTH       = 16,
    parameter int FRAME_CNT_WIDTH = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     run_i,
    input  logic [FRAME_CNT_WIDTH-1:0]               frame_num_i,
    input  logic [IFG_WIDTH-1:0]                     ifg_i,
    input  logic                                     gen_valid_i,
    input  logic [AXIS_DATA_WIDTH-1:0]               gen_data_i,
    input  logic                                     gen_last_i,
    input  logic [bcount_width(AXIS_DATA_WIDTH)-1:0] gen_bytes_i,
    output logic                                     en_o,
    output logic                                     m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic [AXIS_DATA_WIDTH/8-1:0]             m_axis_tstrb,
    output logic                                     m_axis_tlast,
    input  logic                                     m_axis_tready,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic [FRAME_CNT_WIDTH-1:0]               frame_cnt_o
);

    localparam int KW  = AXIS_DATA_WIDTH / 8;
    localparam int BCW = bcount_width(AXIS_DATA_WIDTH);
    localparam int PW  = AXIS_DATA_WIDTH + KW + 1;

    state_t                     state;
    logic [FRAME_CNT_WIDTH-1:0] frame_num_q;
    logic [FRAME_CNT_WIDTH-1:0] acc_cnt;
    logic [FRAME_CNT_WIDTH-1:0] acc_next;
    logic [IFG_WIDTH-1:0]       ifg_q;
    logic [IFG_WIDTH-1:0]       gap_cnt;
    logic                       mid_frame;
    logic                       accept;
    logic                       out_valid;
    logic                       skid_valid;
    logic [MAX_BCW-1:0]         bytes_ext;
    logic [KW-1:0]              keep_in;
    logic [PW-1:0]              in_payload;
    logic [PW-1:0]              out_payload;

    assign en_o   = (state == ST_SEND) && !skid_valid;
    assign accept = en_o && gen_valid_i;
    assign busy_o = (state != ST_IDLE);
    assign done_o = (state == ST_DRAIN) && !out_valid && !skid_valid;

    assign acc_next = (acc_cnt == '1) ? acc_cnt : acc_cnt + FRAME_CNT_WIDTH'(1);

    always_comb begin
        bytes_ext = '0;
        bytes_ext[BCW-1:0] = gen_bytes_i;
    end

    always_comb begin
        keep_in = '1;
        for (int i = 0; i < KW; i++) begin
            if (gen_last_i) keep_in[i] = keep_bit(KW, i, bytes_ext);
        end
    end

    assign in_payload = {gen_last_i, keep_in, gen_data_i};

    axis_udp_gen_skid #(
        .PW (PW)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid   (accept),
        .in_data    (in_payload),
        .out_valid  (out_valid),
        .out_data   (out_payload),
        .out_ready  (m_axis_tready),
        .skid_valid (skid_valid)
    );

    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_payload[PW-1];
    assign m_axis_tkeep  = out_payload[AXIS_DATA_WIDTH +: KW];
    assign m_axis_tstrb  = out_payload[AXIS_DATA_WIDTH +: KW];
    assign m_axis_tdata  = out_payload[AXIS_DATA_WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            frame_num_q <= '0;
            ifg_q       <= '0;
            gap_cnt     <= '0;
            acc_cnt     <= '0;
            mid_frame   <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            if (out_valid && m_axis_tready && m_axis_tlast && frame_cnt_o != '1)
                frame_cnt_o <= frame_cnt_o + FRAME_CNT_WIDTH'(1);

            case (state)
                ST_IDLE: begin
                    if (run_i) begin
                        state       <= ST_SEND;
                        frame_cnt_o <= '0;
                        frame_num_q <= frame_num_i;
                        ifg_q       <= ifg_i;
                        acc_cnt     <= '0;
                        mid_frame   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        if (gen_last_i) begin
                            mid_frame <= 1'b0;
                            acc_cnt   <= acc_next;
                            if ((frame_num_q != '0 && acc_next >= frame_num_q) || !run_i) begin
                                state <= ST_DRAIN;
                            end else if (ifg_q != '0) begin
                                state   <= ST_GAP;
                                gap_cnt <= ifg_q;
                            end
                        end else begin
                            mid_frame <= 1'b1;
                        end
                    end else if (!run_i && !mid_frame) begin
                        // Stopped between frames: nothing partial to finish.
                        state <= ST_DRAIN;
                    end
                end
                ST_GAP: begin
                    if (!run_i) begin
                        state   <= ST_DRAIN;
                        gap_cnt <= '0;
                    end else if (gap_cnt <= IFG_WIDTH'(1)) begin
                        state   <= ST_SEND;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - IFG_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid && !skid_valid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_udp_gen_tx_ctrl.sv
// Scoreboard bench: accepted generator beats queue their expected AXIS beat,
// an output monitor pops and compares every completed transfer.
module tb_axis_udp_gen_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        run;
    logic [31:0] frame_num;
    logic [15:0] ifg;
    logic        gen_valid;
    logic [63:0] gen_data;
    logic        gen_last;
    logic [3:0]  gen_bytes;
    logic        en;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [7:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic        done;
    logic [31:0] frame_cnt;

    // 256-bit instance for the wide keep-mask case
    logic         run2;
    logic         gv2;
    logic [255:0] gd2;
    logic         gl2;
    logic [5:0]   gb2;
    logic         en2;
    logic         tvalid2;
    logic [255:0] tdata2;
    logic [31:0]  tkeep2;
    logic [31:0]  tstrb2;
    logic         tlast2;
    logic         busy2;
    logic         done2;
    logic [31:0]  frame_cnt2;

    axis_udp_gen_tx_ctrl #(.AXIS_DATA_WIDTH(64), .IFG_WIDTH(16), .FRAME_CNT_WIDTH(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .frame_num_i(frame_num), .ifg_i(ifg),
        .gen_valid_i(gen_valid), .gen_data_i(gen_data), .gen_last_i(gen_last),
        .gen_bytes_i(gen_bytes), .en_o(en),
        .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
        .m_axis_tstrb(tstrb), .m_axis_tlast(tlast), .m_axis_tready(tready),
        .busy_o(busy), .done_o(done), .frame_cnt_o(frame_cnt)
    );

    axis_udp_gen_tx_ctrl #(.AXIS_DATA_WIDTH(256), .IFG_WIDTH(16), .FRAME_CNT_WIDTH(32)) u_dut256 (
        .clk_i(clk), .rst_i(rst), .run_i(run2), .frame_num_i(32'd2), .ifg_i(16'd0),
        .gen_valid_i(gv2), .gen_data_i(gd2), .gen_last_i(gl2),
        .gen_bytes_i(gb2), .en_o(en2),
        .m_axis_tvalid(tvalid2), .m_axis_tdata(tdata2), .m_axis_tkeep(tkeep2),
        .m_axis_tstrb(tstrb2), .m_axis_tlast(tlast2), .m_axis_tready(1'b1),
        .busy_o(busy2), .done_o(done2), .frame_cnt_o(frame_cnt2)
    );

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] exp2_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          done_cnt   = 0;
    logic        done_prev  = 1'b0;
    logic        stall_pend = 1'b0;
    beat_t       stall_beat;
    beat_t       mon_e;
    logic [31:0] mon_k2;
    logic        rdy_rand   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Output monitor: scoreboard pop, hold-while-stalled and done width.
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_pend)
                chk("stall_hold", {tvalid, tlast, tkeep, tdata}, {1'b1, stall_beat});
            stall_pend = tvalid && !tready;
            stall_beat = {tlast, tkeep, tdata};
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {tlast, tkeep, tdata}, mon_e);
                    chk("tstrb", tstrb, mon_e.keep);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_single_cycle", {done_prev, done}, 2'b01);
            end
            done_prev = done;
        end
    end

    always @(negedge clk) begin
        if (!rst && tvalid2) begin
            if (exp2_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat_w256: got keep %0h, expected no beat", tkeep2);
            end else begin
                mon_k2 = exp2_q.pop_front();
                chk("w256_tkeep", tkeep2, mon_k2);
                chk("w256_tstrb_tlast", {tstrb2, tlast2}, {mon_k2, 1'b1});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) tready = 1'($urandom_range(0, 1));
    end

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [3:0] b,
                             input logic [7:0] k, output int waits);
        int t = 0;
        gen_valid = 1'b1;
        gen_data  = d;
        gen_last  = l;
        gen_bytes = b;
        @(negedge clk);
        while (!en && t < 300) begin
            t++;
            @(negedge clk);
        end
        waits = t;
        if (!en) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: en_o stayed 0, expected 1");
        end else begin
            exp_q.push_back({l, k, d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [63:0] base, input logic [3:0] b,
                              input logic [7:0] k_last, output int gap);
        int w;
        gap = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(base + 64'(i), i == n - 1, b, (i == n - 1) ? k_last : 8'hFF, w);
            if (i == 0) gap = w;
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        @(negedge clk);
        while (!done && t < 400) begin
            t++;
            @(negedge clk);
        end
        chk(name, done, 1'b1);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_ctl"}, {tvalid, tlast, en, busy, done}, 5'b0);
        chk({name, "_tdata"}, tdata, 64'h0);
        chk({name, "_keep_strb"}, {tkeep, tstrb}, 16'h0);
        chk({name, "_frame_cnt"}, frame_cnt, 32'h0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int act;
        int n;
        int b;
        logic [7:0] k;
        run = 0; frame_num = 0; ifg = 0;
        gen_valid = 0; gen_data = 0; gen_last = 0; gen_bytes = 0;
        tready = 1;
        run2 = 0; gv2 = 0; gd2 = '0; gl2 = 0; gb2 = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk); #1;

        // Three 4-beat frames, no gap, 5 valid bytes on each last beat
        done_cnt = 0;
        frame_num = 3; ifg = 0; run = 1;
        for (int f = 1; f <= 3; f++) begin
            send_frame(4, 64'hA000_0000_0000_0000 + 64'(f * 16), 4'd5, 8'h1F, g);
            if (f > 1) chk("ifg0_no_gap", g, 0);
        end
        gen_valid = 0; run = 0;
        wait_done("burst3_done");
        chk("burst3_frame_cnt", frame_cnt, 32'd3);
        chk("burst3_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("burst3_done_count", done_cnt, 1);
        chk("burst3_idle", {busy, en}, 2'b00);

        // Continuous mode with a 10-cycle inter-frame gap
        @(posedge clk); #1;
        done_cnt = 0;
        frame_num = 0; ifg = 10; run = 1;
        for (int f = 0; f < 4; f++) begin
            send_frame(2, 64'hB000_0000_0000_0000 + 64'(f * 16), 4'd0, 8'hFF, g);
            if (f > 0) begin
                chk("ifg10_gap", g, 10);
                chk("ifg10_frame_cnt", frame_cnt, f);
            end
        end
        gen_valid = 0; run = 0;
        wait_done("ifg10_done");
        chk("ifg10_final_cnt", frame_cnt, 32'd4);
        repeat (2) @(negedge clk);
        chk("ifg10_done_count", done_cnt, 1);

        // Stop requested during beat 2 of a frame: the frame still completes
        @(posedge clk); #1;
        done_cnt = 0;
        frame_num = 0; ifg = 0; run = 1;
        send_frame(4, 64'hC000_0000_0000_0000, 4'd3, 8'h07, g);
        send_beat(64'hC100_0000_0000_0001, 1'b0, 4'd3, 8'hFF, g);
        run = 0;
        send_beat(64'hC100_0000_0000_0002, 1'b0, 4'd3, 8'hFF, g);
        send_beat(64'hC100_0000_0000_0003, 1'b0, 4'd3, 8'hFF, g);
        send_beat(64'hC100_0000_0000_0004, 1'b1, 4'd3, 8'h07, g);
        gen_valid = 0;
        wait_done("stop_done");
        chk("stop_queue_empty_at_done", exp_q.size(), 0);
        chk("stop_frame_cnt", frame_cnt, 32'd2);
        repeat (3) @(negedge clk);
        chk("stop_done_count", done_cnt, 1);
        chk("stop_idle", {busy, en}, 2'b00);

        // 100 frames of 1..4 beats with random backpressure
        @(posedge clk); #1;
        done_cnt = 0;
        frame_num = 100; ifg = 1; run = 1; rdy_rand = 1;
        for (int f = 0; f < 100; f++) begin
            n = 1 + (f % 4);
            b = $urandom_range(0, 8);
            k = (b == 0) ? 8'hFF : (8'hFF >> (8 - b));
            for (int i = 0; i < n; i++)
                send_beat({$urandom, $urandom}, i == n - 1, 4'(b), (i == n - 1) ? k : 8'hFF, g);
        end
        gen_valid = 0; run = 0;
        wait_done("rand_done");
        chk("rand_frame_cnt", frame_cnt, 32'd100);
        chk("rand_queue_empty", exp_q.size(), 0);
        rdy_rand = 0;
        @(posedge clk); #2;
        tready = 1;

        // Reset while the output register and skid both hold beats
        @(posedge clk); #1;
        frame_num = 0; ifg = 0; run = 1;
        send_beat(64'hD000_0000_0000_0001, 1'b1, 4'd0, 8'hFF, g);
        send_beat(64'hD000_0000_0000_0002, 1'b0, 4'd0, 8'hFF, g);
        tready = 0;
        send_beat(64'hD000_0000_0000_0003, 1'b0, 4'd0, 8'hFF, g);
        @(negedge clk);
        chk("skid_full_en_tvalid", {en, tvalid}, 2'b01);
        chk("skid_full_frame_cnt", frame_cnt, 32'd1);
        #2;
        rst = 1;
        #1;
        check_reset("async_reset");
        exp_q.delete();
        run = 0; tready = 1;
        repeat (2) @(posedge clk); #1;
        rst = 0;
        act = 0;
        repeat (8) begin
            @(negedge clk);
            if (tvalid || en) act++;
        end
        chk("post_reset_quiet", act, 0);
        @(posedge clk); #1;
        gen_valid = 0; run = 1;
        @(negedge clk);
        chk("en_after_first_edge", en, 1'b0);
        @(negedge clk);
        chk("en_after_second_edge", en, 1'b1);
        run = 0;
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk); #1;
        rst = 0;

        // 256-bit instance: full last beat, then a 6-byte last beat
        @(posedge clk); #1;
        run2 = 1; gv2 = 1; gl2 = 1; gb2 = 6'd0; gd2 = {8{32'hE0E0_0001}};
        for (int fr = 0; fr < 2; fr++) begin
            g = 0;
            @(negedge clk);
            while (!en2 && g < 50) begin
                g++;
                @(negedge clk);
            end
            chk("w256_en", en2, 1'b1);
            if (en2) exp2_q.push_back(fr == 0 ? 32'hFFFF_FFFF : 32'h0000_003F);
            @(posedge clk); #1;
            gb2 = 6'd6; gd2 = {8{32'hE0E0_0002}};
        end
        gv2 = 0; run2 = 0;
        g = 0;
        @(negedge clk);
        while (!done2 && g < 50) begin
            g++;
            @(negedge clk);
        end
        chk("w256_done", done2, 1'b1);
        chk("w256_frame_cnt", frame_cnt2, 32'd2);
        chk("w256_queue_empty", exp2_q.size(), 0);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
